// File: rtl/mem_bus_device.sv
// mem_bus_device: data-memory bus responder for the CPU.
// Word-addressed data RAM plus an MMIO window holding a reload timer with
// interrupt, an LED register and (optional) free-running SysTick counter.
// Optional feature macro: SYSTICK_EN adds the SysTick register at MMIO_BASE+0x14.
//
// MMIO map (byte offsets from MMIO_BASE):
//   0x00 TH      r/w  reload value
//   0x04 TL      r/w  counter, counts up, reloads from TH after FFFFFFFF
//   0x08 TCON    r/w  [0] enable, [1] irq enable, [2] irq status
//   0x0C LED     r/w  [7:0]
//   0x14 SysTick r/o  (SYSTICK_EN only)
module mem_bus_device #(
  parameter int          RAM_WORDS = 512,
  parameter logic [31:0] MMIO_BASE = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        irq,
  output logic [7:0]  leds
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];

  // Address decode
  logic [29:0]   addr_word;
  logic          sel_ram;
  logic          sel_th;
  logic          sel_tl;
  logic          sel_tcon;
  logic          sel_led;
  logic [AW-1:0] ram_idx;
  logic [1:0]    unused_addr_lsb;

  // Architectural state
  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] th_q,   th_d;
  logic [31:0] tl_q,   tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q,  led_d;
  logic        overflow;
  logic        irq_set;

  assign addr_word       = MemBus_Address[31:2];
  assign unused_addr_lsb = MemBus_Address[1:0];
  assign ram_idx         = MemBus_Address[AW+1:2];

  // Everything below RAM_WORDS*4 is RAM; the MMIO registers are single words.
  assign sel_ram  = (MemBus_Address[31:AW+2] == '0);
  assign sel_th   = (addr_word == MMIO_WORD + 30'd0);
  assign sel_tl   = (addr_word == MMIO_WORD + 30'd1);
  assign sel_tcon = (addr_word == MMIO_WORD + 30'd2);
  assign sel_led  = (addr_word == MMIO_WORD + 30'd3);

`ifdef SYSTICK_EN
  logic        sel_systick;
  logic [31:0] systick_q;

  assign sel_systick = (addr_word == MMIO_WORD + 30'd5);

  // Free-running cycle counter; bus writes to it are deliberately ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick_q <= '0;
    end else begin
      systick_q <= systick_q + 32'd1;
    end
  end
`endif

  // Data RAM: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) begin
      ram_q[ram_idx] <= MemBus_Write_Data;
    end
  end

  assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign irq_set  = overflow && tcon_q[1];

  // Next-state for timer and LED: CPU writes win over counting, except the
  // irq status bit which keeps any overflow set from the same cycle.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;

    if (tcon_q[0]) begin
      // Reload uses the TH value from before this edge, even if TH is being written.
      tl_d = overflow ? th_q : (tl_q + 32'd1);
    end

    if (MemWrite && sel_th) begin
      th_d = MemBus_Write_Data;
    end
    if (MemWrite && sel_tl) begin
      tl_d = MemBus_Write_Data;
    end
    if (MemWrite && sel_tcon) begin
      tcon_d = MemBus_Write_Data[2:0];
    end
    if (MemWrite && sel_led) begin
      led_d = MemBus_Write_Data[7:0];
    end

    tcon_d[2] = tcon_d[2] | irq_set;
  end

  // Timer and LED registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
    end
  end

  // Zero-latency read mux; unmapped addresses and idle bus read as zero.
  always_comb begin
    Device_Read_Data = '0;
    if (MemRead) begin
      if (sel_ram) begin
        Device_Read_Data = ram_q[ram_idx];
      end else if (sel_th) begin
        Device_Read_Data = th_q;
      end else if (sel_tl) begin
        Device_Read_Data = tl_q;
      end else if (sel_tcon) begin
        Device_Read_Data = {29'd0, tcon_q};
      end else if (sel_led) begin
        Device_Read_Data = {24'd0, led_q};
`ifdef SYSTICK_EN
      end else if (sel_systick) begin
        Device_Read_Data = systick_q;
`endif
      end
    end
  end

  assign irq  = tcon_q[2];
  assign leds = led_q;

endmodule

// File: tb/tb_mem_bus_device.sv
// Directed bench for mem_bus_device. Inputs change 1ns after a rising edge;
// reads are combinational and sampled before the next edge.
module tb_mem_bus_device;

  localparam logic [31:0] MB = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic        irq;
  logic [7:0]  leds;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_device #(.RAM_WORDS(512), .MMIO_BASE(MB)) dut (
    .clk               (clk),
    .reset             (reset),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemBus_Address    (MemBus_Address),
    .MemBus_Write_Data (MemBus_Write_Data),
    .Device_Read_Data  (Device_Read_Data),
    .irq               (irq),
    .leds              (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite          = 1'b1;
    MemBus_Address    = a;
    MemBus_Write_Data = d;
    step();
    MemWrite          = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemRead        = 1'b1;
    MemBus_Address = a;
    #1;
    chk(tag, Device_Read_Data, exp);
    MemRead        = 1'b0;
  endtask

  initial begin
    logic [31:0] st_exp0;
    logic [31:0] st_exp1;

    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    MemBus_Address = '0;
    MemBus_Write_Data = '0;
    #1;
    chk("rst_irq",  {31'd0, irq}, 32'd0);
    chk("rst_leds", {24'd0, leds}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_chk("rst_tl",   MB + 32'h4, 32'd0);
    rd_chk("rst_tcon", MB + 32'h8, 32'd0);

    // RAM round trip
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd",     32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd_lsb", 32'h0000_0013, 32'hDEAD_BEEF);
    MemBus_Address = 32'h0000_0010;
    #1;
    chk("ram_noread", Device_Read_Data, 32'd0);

    // Read and write in the same cycle: pre-write value visible, then new one
    MemRead = 1'b1;
    MemWrite = 1'b1;
    MemBus_Address = 32'h0000_0010;
    MemBus_Write_Data = 32'hCAFE_F00D;
    #1;
    chk("rw_same_old", Device_Read_Data, 32'hDEAD_BEEF);
    step();
    MemWrite = 1'b0;
    MemRead = 1'b0;
    rd_chk("rw_same_new", 32'h0000_0010, 32'hCAFE_F00D);

    // Unmapped and out-of-range
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_01FC, 32'h2222_2222);
    wr(32'h0000_0800, 32'h1234_5678);
    rd_chk("oor_rd",      32'h0000_0800, 32'd0);
    rd_chk("ram0_intact", 32'h0000_0000, 32'h1111_1111);
    rd_chk("ram_top",     32'h0000_01FC, 32'h2222_2222);
    rd_chk("mmio_18",     MB + 32'h18, 32'd0);
    rd_chk("mmio_10",     MB + 32'h10, 32'd0);

    // LED register keeps only the low byte
    wr(MB + 32'hC, 32'hFFFF_FF5A);
    rd_chk("led_rd", MB + 32'hC, 32'h0000_005A);
    chk("led_port", {24'd0, leds}, 32'h5A);

    // Timer reload and irq
    wr(MB + 32'h0, 32'hFFFF_FFFC);
    wr(MB + 32'h4, 32'hFFFF_FFFE);
    wr(MB + 32'h8, 32'h0000_0003);
    rd_chk("tl_start", MB + 32'h4, 32'hFFFF_FFFE);
    step();
    rd_chk("tl_edge1", MB + 32'h4, 32'hFFFF_FFFF);
    chk("irq_edge1", {31'd0, irq}, 32'd0);
    step();
    rd_chk("tl_reload", MB + 32'h4, 32'hFFFF_FFFC);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd_chk("tcon_7", MB + 32'h8, 32'd7);
    wr(MB + 32'h8, 32'h0000_0003);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("tl_after_clr", MB + 32'h4, 32'hFFFF_FFFD);
    step();
    rd_chk("tl_keeps", MB + 32'h4, 32'hFFFF_FFFE);

    // Overflow in the same cycle as a TCON write keeps the status bit
    step();
    rd_chk("tl_ff", MB + 32'h4, 32'hFFFF_FFFF);
    wr(MB + 32'h8, 32'h0000_0003);
    rd_chk("tcon_or", MB + 32'h8, 32'd7);
    chk("irq_or", {31'd0, irq}, 32'd1);

    // TL write beats counting; TH write during reload uses old TH
    wr(MB + 32'h4, 32'hFFFF_FFFF);
    rd_chk("tl_wr_wins", MB + 32'h4, 32'hFFFF_FFFF);
    wr(MB + 32'h0, 32'h0000_0100);
    rd_chk("reload_old_th", MB + 32'h4, 32'hFFFF_FFFC);
    rd_chk("th_new", MB + 32'h0, 32'h0000_0100);

    // Asynchronous reset in mid-operation
    wr(MB + 32'hC, 32'h0000_00A5);
    chk("leds_a5", {24'd0, leds}, 32'hA5);
    chk("irq_pre_rst", {31'd0, irq}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_irq",  {31'd0, irq}, 32'd0);
    chk("arst_leds", {24'd0, leds}, 32'd0);
    rd_chk("arst_tl", MB + 32'h4, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rst_hold_tl",   MB + 32'h4, 32'd0);
    rd_chk("rst_hold_tcon", MB + 32'h8, 32'd0);
    rd_chk("rst_hold_th",   MB + 32'h0, 32'd0);
    reset = 1'b0;

    // SysTick
`ifdef SYSTICK_EN
    st_exp0 = 32'd10;
    st_exp1 = 32'd11;
`else
    st_exp0 = 32'd0;
    st_exp1 = 32'd0;
`endif
    repeat (10) step();
    rd_chk("systick_10", MB + 32'h14, st_exp0);
    rd_chk("tl_idle_after_rst", MB + 32'h4, 32'd0);
    wr(MB + 32'h14, 32'd0);
    rd_chk("systick_11", MB + 32'h14, st_exp1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish before 50000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_device.md
Name: mem_bus_device

Overview:
- Bus responder on the CPU data-memory bus. It serves the loads and stores the CPU issues on MemRead/MemWrite/MemBus_Address/MemBus_Write_Data.
- Contains a word-addressed data RAM plus memory-mapped peripherals: a reload timer with interrupt, an LED register, and an optional cycle counter.
- Sits beside the CPU at top level; Device_Read_Data feeds the CPU's memory read path.

Parameters:
- RAM_WORDS, 512, data RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'h40000000, base byte address of the peripheral window.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- MemRead  input  1  CPU load strobe
- MemWrite  input  1  CPU store strobe
- MemBus_Address  input  32  byte address; bits [1:0] ignored
- MemBus_Write_Data  input  32  store data
- Device_Read_Data  output  32  load data, combinational
- irq  output  1  timer interrupt request (= TCON[2])
- leds  output  8  LED register contents

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- On reset assertion, immediately clear:
  - TH, TL, TCON and LED to 0, so irq=0 and leds=0.
  - SysTick to 0 when SYSTICK_EN is defined.
- Reset does not initialise RAM; contents are undefined until written. Reset mid-count aborts the timer at once.
- Address decode (word = MemBus_Address[31:2]):
  - RAM: byte address < RAM_WORDS*4, index = MemBus_Address[log2(RAM_WORDS)+1:2].
  - MMIO_BASE+0x00 TH (r/w, 32b).
  - MMIO_BASE+0x04 TL (r/w, 32b).
  - MMIO_BASE+0x08 TCON (r/w, bits[2:0]; bit0 timer enable, bit1 irq enable, bit2 irq status; bits[31:3] read 0, write ignored).
  - MMIO_BASE+0x0C LED (r/w, bits[7:0]; upper bits read 0).
  - MMIO_BASE+0x14 SysTick (read-only, only with SYSTICK_EN).
  - Any other address is unmapped: reads return 0, writes are ignored.
- Reads:
  - Zero-latency: Device_Read_Data is a combinational function of the address and current state while MemRead=1.
  - Device_Read_Data = 0 when MemRead=0.
- Writes:
  - Committed on the rising clk edge when MemWrite=1.
  - New value is visible to a read in the following cycle.
- MemRead and MemWrite both high to the same address: Device_Read_Data shows the pre-write value in that cycle; the write commits at the edge.
- Timer, each edge while TCON[0]=1:
  - TL==32'hFFFFFFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Otherwise TL<=TL+1.
  - TCON[0]=0: TL holds.
- Simultaneous events:
  - CPU write to TL in the same cycle as a count or reload: the write wins.
  - CPU write to TH while a reload occurs: the reload uses the old TH.
  - CPU write to TCON in the same cycle as an overflow set: new TCON = written value, with bit2 ORed with the overflow set, so no interrupt is lost. Software clears status by writing bit2=0 in a non-overflow cycle.
- irq is TCON[2], registered; there is no combinational path from the bus to irq.

Optional Feature:
- Macro: SYSTICK_EN.
- Defined:
  - 32-bit SysTick register at MMIO_BASE+0x14, increments every clk edge out of reset, wraps FFFFFFFF->0.
  - Writes to it are ignored.
- Undefined: MMIO_BASE+0x14 is unmapped (reads 0) and no counter logic is instantiated.

Test Plan:
- RAM round trip: write 32'hDEADBEEF to 0x00000010, next cycle read 0x00000010 -> 32'hDEADBEEF. Read 0x00000013 (low bits set) -> 32'hDEADBEEF. Read with MemRead=0 -> 0.
- Unmapped and out-of-range: write 0x12345678 to address 0x00000800 (RAM_WORDS=512), then read it -> 0. Read RAM 0x00000000 -> unchanged. Read MMIO_BASE+0x18 -> 0.
- Timer reload and irq:
  - Stimulus: TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3.
  - Edge 1: TL=FFFFFFFF. Edge 2: TL=FFFFFFFC and irq=1.
  - Then write TCON=3 -> irq=0 next cycle, and the timer keeps counting.
- Simultaneous overflow and TCON write: TL=FFFFFFFF, TCON=3, CPU writes TCON=3 on the overflow edge -> TCON reads 7, irq=1.
- Async reset mid-operation:
  - Stimulus: timer running with irq=1 and leds=8'hA5; assert reset between clock edges.
  - Response: irq=0, leds=0, TL reads 0 immediately. Stays cleared with no counting while reset is held.
- SYSTICK_EN build: release reset, wait 10 edges, read MMIO_BASE+0x14 -> 10. A write of 0 to it is ignored (next read -> 11). In the build without the macro, the same read -> 0.
